// File: rtl/readout_pkg.sv
// Shared definitions for the ASIC readout sequencer: FSM states, packet
// framing words and the bit layout of the trailer status word.
package readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_HEAD,
    ST_WAIT_TX,
    ST_RECV,
    ST_TRAIL,
    ST_DONE
  } state_t;

  localparam logic [15:0] HEADER_WORD  = 16'h5AA5;
  localparam logic [15:0] TRAILER_WORD = 16'hA55A;

  localparam int STATUS_TIMEOUT_BIT   = 15;
  localparam int STATUS_TRUNCATED_BIT = 14;
  localparam int STATUS_OVERFLOW_BIT  = 13;

  // Packs the three sticky flags into the last trailer word.
  function automatic logic [15:0] make_status(input logic timeout,
                                              input logic truncated,
                                              input logic overflow);
    logic [15:0] s;
    s = 16'h0;
    s[STATUS_TIMEOUT_BIT]   = timeout;
    s[STATUS_TRUNCATED_BIT] = truncated;
    s[STATUS_OVERFLOW_BIT]  = overflow;
    return s;
  endfunction

endpackage

// File: rtl/readout_watchdog.sv
// Watchdog for the transmit window: counts cycles while Run is high,
// restarts on Restart or whenever Run drops, and flags Expired once LIMIT
// consecutive cycles have elapsed. Only built with READOUT_TIMEOUT_EN.
module readout_watchdog #(
  parameter int LIMIT = 400000
) (
  input  logic Clk,
  input  logic Rst_N,
  input  logic Run,
  input  logic Restart,
  output logic Expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_reg;

  // Cycle counter: cleared outside the window or on activity, holds at LAST.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      cnt_reg <= '0;
    end else if (!Run || Restart) begin
      cnt_reg <= '0;
    end else if (cnt_reg != LAST) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign Expired = Run && !Restart && (cnt_reg == LAST);

endmodule

// File: rtl/readout_sequencer.sv
// ASIC serial readout controller: pulses StartReadout, waits for the
// TransmitOnb window, frames deserialized words as header/data/trailer and
// writes them to the DIF FIFO. Optional watchdog: READOUT_TIMEOUT_EN.
// START_PULSE_LEN must be at least 2.
module readout_sequencer
  import readout_pkg::*;
#(
  parameter int START_PULSE_LEN = 4,
  parameter int MAX_WORDS       = 1580,
  parameter int TIMEOUT_CYCLES  = 400000
) (
  input  logic        Clk,
  input  logic        Rst_N,
  input  logic        In_Start,
  input  logic        In_TransmitOnb,
  input  logic        In_EndReadout,
  input  logic [15:0] In_Word,
  input  logic        In_Word_En,
  input  logic        In_Fifo_Full,
  output logic        Out_StartReadout,
  output logic [15:0] Out_Fifo_Data,
  output logic        Out_Fifo_Wr_En,
  output logic        Out_Busy,
  output logic        Out_Start_Missed
);

  // The pulse register stays high one cycle into HEAD, so START itself
  // only lasts START_PULSE_LEN-1 cycles.
  localparam logic [7:0]  PULSE_LAST = 8'(START_PULSE_LEN - 2);
  localparam logic [15:0] MAX_COUNT  = 16'(MAX_WORDS);

  state_t      state_reg, state_next;
  logic [7:0]  pulse_cnt_reg, pulse_cnt_next;
  logic [1:0]  idx_reg, idx_next;
  logic [15:0] trig_reg, trig_next;
  logic [15:0] count_reg, count_next;
  logic        trunc_reg, trunc_next;
  logic        ovf_reg, ovf_next;
  logic        timeout_flag;

  logic        start_out_reg, start_out_next;
  logic        wr_en_reg, wr_en_next;
  logic [15:0] data_reg, data_next;
  logic        busy_reg, busy_next;
  logic        missed_reg, missed_next;

  logic [1:0]  tx_sync_reg;
  logic [1:0]  end_sync_reg;
  logic        tx_on;
  logic        end_seen;

  // Two-flop synchronizers for the asynchronous ASIC status pins.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      tx_sync_reg  <= 2'b11;
      end_sync_reg <= 2'b00;
    end else begin
      tx_sync_reg  <= {tx_sync_reg[0], In_TransmitOnb};
      end_sync_reg <= {end_sync_reg[0], In_EndReadout};
    end
  end

  assign tx_on    = ~tx_sync_reg[1];
  assign end_seen = end_sync_reg[1];

`ifdef READOUT_TIMEOUT_EN
  logic tmo_reg, tmo_next;
  logic wd_expired;

  readout_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .Clk     (Clk),
    .Rst_N   (Rst_N),
    .Run     ((state_reg == ST_WAIT_TX) || (state_reg == ST_RECV)),
    .Restart (In_Word_En),
    .Expired (wd_expired)
  );

  // Sticky timeout flag, cleared when a new readout starts.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      tmo_reg <= 1'b0;
    end else begin
      tmo_reg <= tmo_next;
    end
  end

  assign timeout_flag = tmo_reg;
`else
  assign timeout_flag = 1'b0;
`endif

  // Next-state, packet framing and data forwarding.
  always_comb begin
    state_next     = state_reg;
    pulse_cnt_next = pulse_cnt_reg;
    idx_next       = idx_reg;
    trig_next      = trig_reg;
    count_next     = count_reg;
    trunc_next     = trunc_reg;
    ovf_next       = ovf_reg;
    wr_en_next     = 1'b0;
    data_next      = 16'h0;
`ifdef READOUT_TIMEOUT_EN
    tmo_next       = tmo_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (In_Start) begin
          state_next     = ST_START;
          pulse_cnt_next = 8'd0;
          count_next     = 16'h0;
          trunc_next     = 1'b0;
          ovf_next       = 1'b0;
`ifdef READOUT_TIMEOUT_EN
          tmo_next       = 1'b0;
`endif
        end
      end

      ST_START: begin
        if (pulse_cnt_reg == PULSE_LAST) begin
          state_next = ST_HEAD;
          idx_next   = 2'd0;
        end else begin
          pulse_cnt_next = pulse_cnt_reg + 8'd1;
        end
      end

      ST_HEAD: begin
        if (!In_Fifo_Full) begin
          wr_en_next = 1'b1;
          if (idx_reg == 2'd0) begin
            data_next = HEADER_WORD;
            idx_next  = 2'd1;
          end else begin
            data_next  = trig_reg;
            state_next = ST_WAIT_TX;
          end
        end
      end

      ST_WAIT_TX: begin
        if (tx_on) begin
          state_next = ST_RECV;
        end
`ifdef READOUT_TIMEOUT_EN
        else if (wd_expired) begin
          tmo_next   = 1'b1;
          state_next = ST_TRAIL;
          idx_next   = 2'd0;
        end
`endif
      end

      ST_RECV: begin
        if (In_Word_En) begin
          if (count_reg >= MAX_COUNT) begin
            trunc_next = 1'b1;
          end
          if (In_Fifo_Full) begin
            ovf_next = 1'b1;
          end
          if ((count_reg < MAX_COUNT) && !In_Fifo_Full) begin
            wr_en_next = 1'b1;
            data_next  = In_Word;
            count_next = count_reg + 16'd1;
          end
        end
        if (!tx_on && end_seen) begin
          state_next = ST_TRAIL;
          idx_next   = 2'd0;
        end
`ifdef READOUT_TIMEOUT_EN
        else if (wd_expired) begin
          tmo_next   = 1'b1;
          state_next = ST_TRAIL;
          idx_next   = 2'd0;
        end
`endif
      end

      ST_TRAIL: begin
        if (!In_Fifo_Full) begin
          wr_en_next = 1'b1;
          case (idx_reg)
            2'd0:    data_next = TRAILER_WORD;
            2'd1:    data_next = count_reg;
            default: data_next = make_status(timeout_flag, trunc_reg, ovf_reg);
          endcase
          if (idx_reg == 2'd2) begin
            state_next = ST_DONE;
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end
      end

      ST_DONE: begin
        trig_next  = trig_reg + 16'd1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Registered outputs derived from the transition being taken this cycle.
  always_comb begin
    start_out_next = (state_next == ST_START) || (state_reg == ST_START);
    busy_next      = (state_next != ST_IDLE);
    missed_next    = In_Start && busy_reg;
  end

  // FSM and output registers.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_reg     <= ST_IDLE;
      pulse_cnt_reg <= 8'd0;
      idx_reg       <= 2'd0;
      trig_reg      <= 16'h0;
      count_reg     <= 16'h0;
      trunc_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
      start_out_reg <= 1'b0;
      wr_en_reg     <= 1'b0;
      data_reg      <= 16'h0;
      busy_reg      <= 1'b0;
      missed_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pulse_cnt_reg <= pulse_cnt_next;
      idx_reg       <= idx_next;
      trig_reg      <= trig_next;
      count_reg     <= count_next;
      trunc_reg     <= trunc_next;
      ovf_reg       <= ovf_next;
      start_out_reg <= start_out_next;
      wr_en_reg     <= wr_en_next;
      data_reg      <= data_next;
      busy_reg      <= busy_next;
      missed_reg    <= missed_next;
    end
  end

  assign Out_StartReadout = start_out_reg;
  assign Out_Fifo_Wr_En   = wr_en_reg;
  assign Out_Fifo_Data    = data_reg;
  assign Out_Busy         = busy_reg;
  assign Out_Start_Missed = missed_reg;

endmodule

// File: doc/readout_sequencer.md
# readout_sequencer

Controller for the ASIC serial readout path. After each acquisition it pulses the ASIC StartReadout line and waits for the chip's TransmitOnb window. It frames the 16-bit words coming out of the Dout deserializer into a header/data/trailer packet and writes the packet into the DIF readout FIFO. It sits between the acquisition state machine (upstream), the deserializer (sideways) and the USB/FIFO path (downstream).

## Interface
- START_PULSE_LEN, 4: cycles Out_StartReadout is held high.
- MAX_WORDS, 1580: maximum data words accepted per readout; words beyond this are dropped.
- TIMEOUT_CYCLES, 400000: watchdog limit, 10 ms at 40 MHz (used only with the macro).

Ports:
- Clk  in  1  40 MHz system clock, same as the deserializer clock.
- Rst_N  in  1  reset; asynchronous, active-low.
- In_Start  in  1  one-cycle request from the acquisition FSM (acquisition finished).
- In_TransmitOnb  in  1  ASIC transmit window, low active; asynchronous to Clk.
- In_EndReadout  in  1  end-of-chain flag from the last ASIC; asynchronous to Clk.
- In_Word  in  16  deserialized data word.
- In_Word_En  in  1  one-cycle strobe qualifying In_Word.
- In_Fifo_Full  in  1  downstream FIFO full.
- Out_StartReadout  out  1  StartReadout to the ASIC chain.
- Out_Fifo_Data  out  16  packet word.
- Out_Fifo_Wr_En  out  1  write strobe.
- Out_Busy  out  1  high from acceptance of In_Start until back in IDLE.
- Out_Start_Missed  out  1  one-cycle pulse when In_Start arrives while busy.

## Operation
- In_TransmitOnb and In_EndReadout each pass through a 2-flop synchronizer. The FSM uses only the synchronized copies (TxOn = ~sync TransmitOnb).
- The FSM has seven states:
  - IDLE: on In_Start, latch the trigger ID and go to START.
  - START: drive Out_StartReadout for START_PULSE_LEN cycles, then go to HEAD.
  - HEAD: write 16'h5AA5, then the trigger ID, then go to WAIT_TX.
  - WAIT_TX: go to RECV when TxOn rises.
  - RECV: forward each In_Word_En word to the FIFO. Go to TRAIL when TxOn is low and sync EndReadout is high on the same cycle.
  - TRAIL: write 16'hA55A, then the data word count, then the status word {Timeout, Truncated, Overflow, 13'd0}.
  - DONE: one cycle; trigger ID increments by 1 (16-bit, wraps 16'hFFFF to 0); return to IDLE.
- Data words:
  - The word count is 16 bits and counts only words actually written.
  - Once the count equals MAX_WORDS, further words are dropped and Truncated is set.
  - A data word arriving while In_Fifo_Full is high is dropped and Overflow is set; it is not counted.
- Header and trailer words never drop: the FSM holds in place while In_Fifo_Full is high.
- In_Word_En outside RECV is ignored.
- In_Start while Out_Busy is high is ignored and produces Out_Start_Missed. In_Start in IDLE never produces the pulse.
- Flags and word count clear on entry to START.

## Timing
- Reset values:
  - Out_StartReadout, Out_Fifo_Wr_En, Out_Busy, Out_Start_Missed = 0.
  - Out_Fifo_Data = 16'h0; trigger ID = 0; FSM = IDLE.
- Reset asserted mid-packet aborts immediately. No trailer is written and the trigger ID returns to 0.
- In_Start high at edge N gives Out_Busy = 1 and Out_StartReadout = 1 at edge N+1. Out_StartReadout falls at N+1+START_PULSE_LEN.
- Header word 0 is written at N+1+START_PULSE_LEN; header word 1 follows on the next cycle unless the FIFO is full.
- Data latency is one cycle: In_Word_En at edge M gives Out_Fifo_Wr_En with the same word at M+1.
- Out_Fifo_Data is 16'h0 whenever Out_Fifo_Wr_En is low.
- TxOn deassertion is seen 2 cycles after the pin. TRAIL's first write happens 1 cycle after detection.
- Simultaneous In_Word_En and end detection: the word is written first, then the trailer on the next cycle.
- With an empty FIFO, TRAIL writes on three consecutive cycles. DONE follows; Out_Busy falls at the DONE→IDLE edge.

## Configuration
- READOUT_TIMEOUT_EN defined:
  - A watchdog counts cycles in WAIT_TX and RECV and restarts on every In_Word_En.
  - Reaching TIMEOUT_CYCLES sets Timeout and forces TRAIL.
  - Out_StartReadout is not retried.
- Undefined: no counter is instantiated; WAIT_TX/RECV wait indefinitely; the Timeout status bit is constant 0.

## Structure
- Shared package readout_pkg holds:
  - the FSM state enum;
  - HEADER_WORD 16'h5AA5 and TRAILER_WORD 16'hA55A;
  - status bit positions.
- Sub-module readout_watchdog: load/restart/expire counter, instantiated only under READOUT_TIMEOUT_EN.
- Synchronizers stay inline.

## Test plan
- Normal readout, 5 words 16'h0001..0005, FIFO empty → FIFO receives:
  - 5AA5, 0000, 0001..0005, A55A, 0005, 0000;
  - Out_StartReadout high exactly 4 cycles; trigger ID 1 on the next packet.
- 1585 words in one window → 1580 written, count word 1580 (16'h062C), status 16'h4000 (Truncated).
- In_Fifo_Full high for 3 cycles during RECV while 2 words arrive → both dropped, status 16'h2000. A further 3 full cycles during TRAIL → the trailer stalls 3 cycles and all three trailer words are written.
- In_Start pulsed while in RECV → one Out_Start_Missed pulse; packet unaffected.
- Rst_N low during RECV → all outputs 0 next cycle; FSM returns to IDLE. A following In_Start gives trigger ID 0.
- With READOUT_TIMEOUT_EN and TIMEOUT_CYCLES=100, TransmitOnb never falls → after 100 cycles in WAIT_TX the trailer is written: A55A, 0000, 8000.
